// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32 x 64-bit register file.
//   DATA_W   : register / data-port width
//   ADDR_W   : register address width
//   NUM_REGS : number of registers (2**ADDR_W)
package reg_file_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg64_en.sv
// Single register with asynchronous active-low clear and synchronous load.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low clear
//   load  : synchronous load enable
//   d     : load data
//   q     : register contents
module reg64_en #(
  parameter int WIDTH = reg_file_pkg::DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file: one synchronous write port, two asynchronous
// read ports. Storage instances are named R00..R31 so they can be probed
// hierarchically (the contents are R<nn>.q).
// Ports (positional order fixed):
//   D     : write data
//   DA    : write address
//   SA    : read address, port A
//   SB    : read address, port B
//   W     : write enable, active-high
//   reset : asynchronous active-low clear of all registers
//   clock : rising-edge clock
//   A     : R[SA], combinational
//   B     : R[SB], combinational
// Build option: define ZERO_REG_EN to hardwire R31 to zero (writes to
// address 31 are dropped, reads of address 31 return zero).
module reg_file_32x64
  import reg_file_pkg::*;
(
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] DA,
  input  logic [ADDR_W-1:0] SA,
  input  logic [ADDR_W-1:0] SB,
  input  logic              W,
  input  logic              reset,
  input  logic              clock,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B
);

  localparam reg_addr_t ZERO_IDX = reg_addr_t'(NUM_REGS - 1);

  logic [NUM_REGS-1:0] load;
  word_t               q [NUM_REGS];
  word_t               d31;

  // Write-address decoder.
  always_comb begin
    load = '0;
    if (W)
      load[DA] = 1'b1;
`ifdef ZERO_REG_EN
    load[ZERO_IDX] = 1'b0;
`endif
  end

`ifdef ZERO_REG_EN
  // R31 keeps its instance but can only ever hold zero.
  assign d31 = '0;
`else
  assign d31 = D;
`endif

  reg64_en #(.WIDTH(DATA_W)) R00 (.clock(clock), .reset(reset), .load(load[0]),  .d(D),   .q(q[0]));
  reg64_en #(.WIDTH(DATA_W)) R01 (.clock(clock), .reset(reset), .load(load[1]),  .d(D),   .q(q[1]));
  reg64_en #(.WIDTH(DATA_W)) R02 (.clock(clock), .reset(reset), .load(load[2]),  .d(D),   .q(q[2]));
  reg64_en #(.WIDTH(DATA_W)) R03 (.clock(clock), .reset(reset), .load(load[3]),  .d(D),   .q(q[3]));
  reg64_en #(.WIDTH(DATA_W)) R04 (.clock(clock), .reset(reset), .load(load[4]),  .d(D),   .q(q[4]));
  reg64_en #(.WIDTH(DATA_W)) R05 (.clock(clock), .reset(reset), .load(load[5]),  .d(D),   .q(q[5]));
  reg64_en #(.WIDTH(DATA_W)) R06 (.clock(clock), .reset(reset), .load(load[6]),  .d(D),   .q(q[6]));
  reg64_en #(.WIDTH(DATA_W)) R07 (.clock(clock), .reset(reset), .load(load[7]),  .d(D),   .q(q[7]));
  reg64_en #(.WIDTH(DATA_W)) R08 (.clock(clock), .reset(reset), .load(load[8]),  .d(D),   .q(q[8]));
  reg64_en #(.WIDTH(DATA_W)) R09 (.clock(clock), .reset(reset), .load(load[9]),  .d(D),   .q(q[9]));
  reg64_en #(.WIDTH(DATA_W)) R10 (.clock(clock), .reset(reset), .load(load[10]), .d(D),   .q(q[10]));
  reg64_en #(.WIDTH(DATA_W)) R11 (.clock(clock), .reset(reset), .load(load[11]), .d(D),   .q(q[11]));
  reg64_en #(.WIDTH(DATA_W)) R12 (.clock(clock), .reset(reset), .load(load[12]), .d(D),   .q(q[12]));
  reg64_en #(.WIDTH(DATA_W)) R13 (.clock(clock), .reset(reset), .load(load[13]), .d(D),   .q(q[13]));
  reg64_en #(.WIDTH(DATA_W)) R14 (.clock(clock), .reset(reset), .load(load[14]), .d(D),   .q(q[14]));
  reg64_en #(.WIDTH(DATA_W)) R15 (.clock(clock), .reset(reset), .load(load[15]), .d(D),   .q(q[15]));
  reg64_en #(.WIDTH(DATA_W)) R16 (.clock(clock), .reset(reset), .load(load[16]), .d(D),   .q(q[16]));
  reg64_en #(.WIDTH(DATA_W)) R17 (.clock(clock), .reset(reset), .load(load[17]), .d(D),   .q(q[17]));
  reg64_en #(.WIDTH(DATA_W)) R18 (.clock(clock), .reset(reset), .load(load[18]), .d(D),   .q(q[18]));
  reg64_en #(.WIDTH(DATA_W)) R19 (.clock(clock), .reset(reset), .load(load[19]), .d(D),   .q(q[19]));
  reg64_en #(.WIDTH(DATA_W)) R20 (.clock(clock), .reset(reset), .load(load[20]), .d(D),   .q(q[20]));
  reg64_en #(.WIDTH(DATA_W)) R21 (.clock(clock), .reset(reset), .load(load[21]), .d(D),   .q(q[21]));
  reg64_en #(.WIDTH(DATA_W)) R22 (.clock(clock), .reset(reset), .load(load[22]), .d(D),   .q(q[22]));
  reg64_en #(.WIDTH(DATA_W)) R23 (.clock(clock), .reset(reset), .load(load[23]), .d(D),   .q(q[23]));
  reg64_en #(.WIDTH(DATA_W)) R24 (.clock(clock), .reset(reset), .load(load[24]), .d(D),   .q(q[24]));
  reg64_en #(.WIDTH(DATA_W)) R25 (.clock(clock), .reset(reset), .load(load[25]), .d(D),   .q(q[25]));
  reg64_en #(.WIDTH(DATA_W)) R26 (.clock(clock), .reset(reset), .load(load[26]), .d(D),   .q(q[26]));
  reg64_en #(.WIDTH(DATA_W)) R27 (.clock(clock), .reset(reset), .load(load[27]), .d(D),   .q(q[27]));
  reg64_en #(.WIDTH(DATA_W)) R28 (.clock(clock), .reset(reset), .load(load[28]), .d(D),   .q(q[28]));
  reg64_en #(.WIDTH(DATA_W)) R29 (.clock(clock), .reset(reset), .load(load[29]), .d(D),   .q(q[29]));
  reg64_en #(.WIDTH(DATA_W)) R30 (.clock(clock), .reset(reset), .load(load[30]), .d(D),   .q(q[30]));
  reg64_en #(.WIDTH(DATA_W)) R31 (.clock(clock), .reset(reset), .load(load[31]), .d(d31), .q(q[31]));

  // Read ports: no write bypass, so a port addressing DA shows the old value
  // until the edge that loads the register.
`ifdef ZERO_REG_EN
  assign A = (SA == ZERO_IDX) ? '0 : q[SA];
  assign B = (SB == ZERO_IDX) ? '0 : q[SB];
`else
  assign A = q[SA];
  assign B = q[SB];
`endif

endmodule

// File: tb/tb_reg_file_32x64.sv
module tb_reg_file_32x64;

  logic [63:0] D;
  logic [4:0]  DA, SA, SB;
  logic        W, reset, clock;
  logic [63:0] A, B;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [63:0] model [32];
  logic [63:0] sweep_d [32];

  reg_file_32x64 dut (
    .D(D), .DA(DA), .SA(SA), .SB(SB), .W(W),
    .reset(reset), .clock(clock), .A(A), .B(B)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected content after the sweep, honouring the zero register option.
  function automatic logic [63:0] swept(input int k);
`ifdef ZERO_REG_EN
    if (k == 31) return 64'h0;
`endif
    return sweep_d[k];
  endfunction

  // Reference model: an array of words updated by the architectural rules.
  initial for (int i = 0; i < 32; i++) model[i] = 64'h0;

  always @(negedge reset)
    for (int i = 0; i < 32; i++) model[i] = 64'h0;

  always @(posedge clock) begin
    if (reset === 1'b1 && W === 1'b1) begin
`ifdef ZERO_REG_EN
      if (DA != 5'd31)
`endif
        model[DA] = D;
    end
  end

  // Mid-cycle comparison of both read ports against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp_a", A, model[SA]);
      chk("cmp_b", B, model[SB]);
    end
  end

  initial begin
    // 1. reset held with a write pending
    reset = 1'b0; W = 1'b1; D = 64'hDEAD_BEEF_CAFE_F00D; DA = 5'd0;
    SA = 5'd0; SB = 5'd0;
    #1 chk_en = 1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i++) begin
      SA = 5'(i); SB = 5'(31 - i);
      #1;
      chk("reset_a", A, 64'h0);
      chk("reset_b", B, 64'h0);
    end
    chk("reset_r00", dut.R00.q, 64'h0);
    chk("reset_r31", dut.R31.q, 64'h0);

    // 2. sweep writes, release reset mid-cycle
    @(posedge clock);
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sweep_d[i] = {$urandom, $urandom};
      DA = 5'(i); D = sweep_d[i]; W = 1'b1;
      SA = 5'(i - 1); SB = 5'(i - 2);
      @(posedge clock);
      #1;
      chk("sweep_a", A, (i >= 1) ? sweep_d[i-1] : 64'h0);
      chk("sweep_b", B, (i >= 2) ? sweep_d[i-2] : 64'h0);
    end

    // 3. write disabled
    W = 1'b0;
    for (int i = 0; i < 32; i++) begin
      D = {$urandom, $urandom}; DA = 5'($urandom_range(0, 31));
      SA = 5'(i); SB = 5'(31 - i);
      @(posedge clock);
      #1;
      chk("hold_a", A, swept(i));
      chk("hold_b", B, swept(31 - i));
    end

    // 4. read during write
    W = 1'b1; DA = 5'd5; D = 64'h1111; SA = 5'd5; SB = 5'd5;
    @(posedge clock);
    #1 D = 64'h2222;
    #1;
    chk("rdw_a_before", A, 64'h1111);
    chk("rdw_b_before", B, 64'h1111);
    @(posedge clock);
    #1;
    chk("rdw_a_after", A, 64'h2222);
    chk("rdw_b_after", B, 64'h2222);
    chk("rdw_r05", dut.R05.q, 64'h2222);
    W = 1'b0;

    // 6. zero register option
    W = 1'b1; DA = 5'd31; D = 64'hFFFF_FFFF_FFFF_FFFF; SA = 5'd31; SB = 5'd0;
    #1 chk("r31_before", A, swept(31));
    @(posedge clock);
    #1 W = 1'b0;
`ifdef ZERO_REG_EN
    chk("r31_read", A, 64'h0);
    chk("r31_probe", dut.R31.q, 64'h0);
`else
    chk("r31_read", A, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("r31_probe", dut.R31.q, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    chk("r00_keep", B, sweep_d[0]);

    // 5. async reset between edges with a write attempted
    W = 1'b1; DA = 5'd3; D = 64'hABCD_0123_4567_89EF; SA = 5'd3; SB = 5'd5;
    #2 reset = 1'b0;
    #1;
    chk("areset_a", A, 64'h0);
    chk("areset_b", B, 64'h0);
    @(posedge clock);
    #1;
    chk("areset_wr_a", A, 64'h0);
    chk("areset_r03", dut.R03.q, 64'h0);
    W = 1'b0;
    #1 reset = 1'b1;
    #1 chk("post_reset_a", A, 64'h0);
    repeat (3) @(posedge clock);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
